// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-8 serial-to-parallel demultiplexer.
package demux_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2,
    STALL   = 2'd3
  } demux_state_t;

  // Returns 1 when data plus its even-parity bit has an odd number of ones.
  function automatic logic parity_err(input logic [63:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/demux_1x8_dec.sv
// Index-to-one-hot write-enable decoder for the deserializer shift register.
module demux_1x8_dec #(
  parameter int DATA_W = 8
) (
  input  logic [$clog2(DATA_W)-1:0] idx,
  input  logic                      en,
  output logic [DATA_W-1:0]         we
);

  always_comb begin
    we      = '0;
    we[idx] = en;
  end

endmodule

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel 1-to-8 demultiplexer, LSB first, valid/ready on both sides.
// Optional even-parity bit per frame when DEMUX_PARITY_EN is defined.
module demux_1x8_deser
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_bit,
  input  logic                      in_sof,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_err,
  output logic                      sync_err,
  output logic [$clog2(DATA_W)-1:0] sel_idx
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and out_* hold while out_valid && !out_ready.

  localparam int             IW   = $clog2(DATA_W);
  localparam logic [IW-1:0]  LAST = IW'(DATA_W - 1);

  demux_state_t      state, state_d;
  logic [IW-1:0]     idx, idx_d, wr_idx;
  logic [DATA_W-1:0] shreg, shreg_d, we;
  logic              wr_en, load, load_err, err_pend, err_pend_d, sync_d;
  logic              acc, out_free;

  assign in_ready = (state != STALL);
  assign acc      = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign sel_idx  = idx;

  demux_1x8_dec #(.DATA_W(DATA_W)) u_dec (
    .idx (wr_idx),
    .en  (wr_en),
    .we  (we)
  );

  assign shreg_d = (shreg & ~we) | ({DATA_W{in_bit}} & we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    wr_en      = 1'b0;
    wr_idx     = idx;
    load       = 1'b0;
    load_err   = 1'b0;
    err_pend_d = err_pend;
    sync_d     = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (in_sof) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            idx_d   = IW'(1);
            state_d = COLLECT;
          end else begin
            sync_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (acc) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // Resync: the partial byte is abandoned, this bit starts a new one.
            wr_idx = '0;
            idx_d  = IW'(1);
            sync_d = 1'b1;
          end else begin
            idx_d = idx + IW'(1);
            if (idx == LAST) begin
`ifdef DEMUX_PARITY_EN
              state_d = PARITY;
`else
              if (out_free) begin
                load    = 1'b1;
                state_d = IDLE;
              end else begin
                err_pend_d = 1'b0;
                state_d    = STALL;
              end
`endif
            end
          end
        end
      end
      PARITY: begin
`ifdef DEMUX_PARITY_EN
        if (acc) begin
          if (in_sof) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            idx_d   = IW'(1);
            sync_d  = 1'b1;
            state_d = COLLECT;
          end else if (out_free) begin
            load     = 1'b1;
            load_err = parity_err(64'(shreg), in_bit);
            state_d  = IDLE;
          end else begin
            err_pend_d = parity_err(64'(shreg), in_bit);
            state_d    = STALL;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      STALL: begin
        if (out_free) begin
          load     = 1'b1;
          load_err = err_pend;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      shreg    <= '0;
      err_pend <= 1'b0;
    end else begin
      idx      <= idx_d;
      shreg    <= shreg_d;
      err_pend <= err_pend_d;
    end
  end

  // Output register; a load in the handshake cycle keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= sync_d;
      if (load) begin
        out_data  <= shreg_d;
        out_valid <= 1'b1;
        out_err   <= load_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Directed, table-driven bench for demux_1x8_deser; also covers the DEMUX_PARITY_EN build.
module tb_demux_1x8_deser;

`ifdef DEMUX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic       clk, rst_n;
  logic       in_bit, in_sof, in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_err, sync_err;
  logic [2:0] sel_idx;

  int checks   = 0;
  int failures = 0;

  demux_1x8_deser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err),
    .sync_err  (sync_err),
    .sel_idx   (sel_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v, sof, b, rdy;
    logic       eov;
    logic [7:0] eod;
    logic       eir, ese;
    logic [2:0] eidx;
    logic       eerr;
  } vec_t;

  vec_t tbl [0:127];
  int   n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic eov, input logic [7:0] eod,
                            input logic eir, input logic ese, input logic [2:0] eidx,
                            input logic eerr);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    chk({tag, ".out_data"},  32'(out_data),  32'(eod));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(eir));
    chk({tag, ".sync_err"},  32'(sync_err),  32'(ese));
    chk({tag, ".sel_idx"},   32'(sel_idx),   32'(eidx));
    chk({tag, ".out_err"},   32'(out_err),   32'(eerr));
  endtask

  // Drive one cycle of inputs, clock it, then check outputs 1 time unit after the edge.
  task automatic cyc(input string tag, input logic v, input logic sof, input logic b,
                     input logic rdy, input logic eov, input logic [7:0] eod,
                     input logic eir, input logic ese, input logic [2:0] eidx,
                     input logic eerr);
    @(negedge clk);
    in_valid  = v;
    in_sof    = sof;
    in_bit    = b;
    out_ready = rdy;
    @(posedge clk);
    #1;
    check_outs(tag, eov, eod, eir, ese, eidx, eerr);
  endtask

  task automatic add(input logic v, input logic sof, input logic b, input logic rdy,
                     input logic eov, input logic [7:0] eod, input logic eir,
                     input logic ese, input logic [2:0] eidx);
    tbl[n] = '{v: v, sof: sof, b: b, rdy: rdy, eov: eov, eod: eod,
               eir: eir, ese: ese, eidx: eidx, eerr: 1'b0};
    n++;
  endtask

  // Streaming frame with out_ready=1: the previous byte drains on the sof cycle.
  task automatic add_byte(input logic [7:0] d, input logic [7:0] prev_od);
    for (int i = 0; i < 8; i++) begin
      logic last;
      last = (NPAR == 0) && (i == 7);
      add(1'b1, i == 0, d[i], 1'b1, last, last ? d : prev_od, 1'b1, 1'b0, 3'((i + 1) % 8));
    end
    if (NPAR != 0) add(1'b1, 1'b0, ^d, 1'b1, 1'b1, d, 1'b1, 1'b0, 3'd0);
  endtask

  // Hand-driven frame: h* are held outputs during the frame, l* apply after the final bit.
  task automatic feed_byte(input string tag, input logic [7:0] d, input logic rdy,
                           input logic hov, input logic [7:0] hod,
                           input logic lov, input logic [7:0] lod, input logic lir,
                           input logic pflip, input logic lerr);
    for (int i = 0; i < 8; i++) begin
      logic last;
      last = (NPAR == 0) && (i == 7);
      cyc(tag, 1'b1, i == 0, d[i], rdy, last ? lov : hov, last ? lod : hod,
          last ? lir : 1'b1, 1'b0, 3'((i + 1) % 8), last ? lerr : 1'b0);
    end
    if (NPAR != 0)
      cyc(tag, 1'b1, 1'b0, (^d) ^ pflip, rdy, lov, lod, lir, 1'b0, 3'd0, lerr);
  endtask

  initial begin
    int mark;
    rst_n     = 1'b0;
    in_bit    = 1'b0;
    in_sof    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single byte, back-to-back bytes, sync errors.
    add_byte(8'h4D, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b1, 1'b0, 3'd0);
    add_byte(8'hA5, 8'h4D);
    add_byte(8'h3C, 8'hA5);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 3'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 3'd0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 3'd1);
    for (int i = 0; i < 4; i++)
      add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 3'(i + 2));
    mark = n;
    add_byte(8'h96, 8'h3C);
    tbl[mark].ese = 1'b1;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h96, 1'b1, 1'b0, 3'd0);

    for (int k = 0; k < n; k++)
      cyc($sformatf("vec%0d", k), tbl[k].v, tbl[k].sof, tbl[k].b, tbl[k].rdy,
          tbl[k].eov, tbl[k].eod, tbl[k].eir, tbl[k].ese, tbl[k].eidx, tbl[k].eerr);

    // Stall: 0x11 held with out_ready=0, then 0xFF completes and must wait.
    feed_byte("held11", 8'h11, 1'b0, 1'b0, 8'h96, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    feed_byte("stallff", 8'hFF, 1'b0, 1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc("stall_hold0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc("stall_hold1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc("stall_drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc("stall_done",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);

    // Reset mid-frame after bit 5, then a clean 0x80.
    cyc("pre_rst_sof", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd1, 1'b0);
    for (int i = 1; i <= 5; i++)
      cyc("pre_rst_bit", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 3'(i + 1), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_outs("in_rst", 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("in_rst_hold", 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    feed_byte("after_rst", 8'h80, 1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    cyc("after_rst_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 3'd0, 1'b0);

`ifdef DEMUX_PARITY_EN
    feed_byte("par_ok",  8'h07, 1'b1, 1'b0, 8'h80, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    feed_byte("par_bad", 8'h07, 1'b1, 1'b0, 8'h07, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
